// File: rtl/alu_sweep_pkg.sv
// Shared definitions for the ALU sweep sequencer: FSM state codes, sweep length,
// MISR taps, the default seed and the MISR step function.
package alu_sweep_pkg;

  localparam int unsigned SWEEP_OPCODES = 16;
  localparam logic [3:0]  LAST_OPCODE   = 4'(SWEEP_OPCODES - 1);
  localparam logic [31:0] DEFAULT_SEED  = 32'hFFFF_FFFF;

  localparam int unsigned MISR_TAP3 = 31;
  localparam int unsigned MISR_TAP2 = 21;
  localparam int unsigned MISR_TAP1 = 1;
  localparam int unsigned MISR_TAP0 = 0;

  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StDrive   = 2'd1;
  localparam state_t StCapture = 2'd2;
  localparam state_t StDone    = 2'd3;

  // data = {cout, bout, result}; the flags fold into the two LSBs.
  function automatic logic [31:0] misr_next(logic [31:0] cur, logic [33:0] data);
    logic fb;
    fb = cur[MISR_TAP3] ^ cur[MISR_TAP2] ^ cur[MISR_TAP1] ^ cur[MISR_TAP0];
    return {cur[30:0], fb} ^ data[31:0] ^ {30'b0, data[33:32]};
  endfunction

endpackage

// File: rtl/alu_sweep_seq_if.sv
// ALU-side bus of the sweep sequencer: stimulus towards the ALU, results back.
interface alu_sweep_seq_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic        alu_bin;
  logic [3:0]  alu_opcode;
  logic        alu_en;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        alu_bout;

  modport master (
    output alu_a, alu_b, alu_cin, alu_bin, alu_opcode, alu_en,
    input  alu_result, alu_cout, alu_bout
  );

  modport slave (
    input  alu_a, alu_b, alu_cin, alu_bin, alu_opcode, alu_en,
    output alu_result, alu_cout, alu_bout
  );
endinterface

// File: rtl/alu_sweep_misr.sv
// 32-bit MISR compacting 34-bit ALU samples; clr has priority over load_seed over shift.
module alu_sweep_misr
  import alu_sweep_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load_seed,
  input  logic        shift,
  input  logic [33:0] data,
  output logic [31:0] sig
);

  logic [31:0] sig_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sig_q <= '0;
    end else if (load_seed) begin
      sig_q <= SEED;
    end else if (shift) begin
      sig_q <= misr_next(sig_q, data);
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_sweep_seq.sv
// ALU self-test sequencer: sweeps all opcodes on one latched operand pair and folds
// each sample into a MISR. Optional trace port enabled by ALU_SWEEP_SEQ_TRACE_EN.
module alu_sweep_seq
  import alu_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            a_in,
  input  logic [31:0]            b_in,
  input  logic                   cin_in,
  input  logic                   bin_in,
  alu_sweep_seq_if.master        alu,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            sig,
  output logic                   sig_valid
`ifdef ALU_SWEEP_SEQ_TRACE_EN
  ,
  output logic                   trace_valid,
  output logic [3:0]             trace_opcode,
  output logic [31:0]            trace_result,
  output logic [1:0]             trace_flags
`endif
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sig_valid_q, sig_valid_d;
  logic [31:0] a_q, b_q;
  logic        cin_q, bin_q;
  logic        latch;
  logic        shift;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    en_d        = en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sig_valid_d = sig_valid_q;
    latch       = 1'b0;
    shift       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          latch       = 1'b1;
          opcode_d    = '0;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          sig_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCapture: begin
        shift = 1'b1;
        // done/en/sig_valid are set on entry so they line up with the DONE cycle.
        if (opcode_q == LAST_OPCODE) begin
          state_d     = StDone;
          en_d        = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          sig_valid_d = 1'b1;
        end else begin
          opcode_d = opcode_q + 4'd1;
          cnt_d    = '0;
          state_d  = StDrive;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      sig_valid_d = 1'b0;
      shift       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      opcode_q    <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      bin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sig_valid_q <= sig_valid_d;
      if (latch) begin
        a_q   <= a_in;
        b_q   <= b_in;
        cin_q <= cin_in;
        bin_q <= bin_in;
      end
    end
  end

  alu_sweep_misr #(
    .SEED(SEED)
  ) u_misr (
    .clk      (clk),
    .clr      (rst),
    .load_seed(latch),
    .shift    (shift),
    .data     ({alu.alu_cout, alu.alu_bout, alu.alu_result}),
    .sig      (sig)
  );

  assign alu.alu_a      = a_q;
  assign alu.alu_b      = b_q;
  assign alu.alu_cin    = cin_q;
  assign alu.alu_bin    = bin_q;
  assign alu.alu_opcode = opcode_q;
  assign alu.alu_en     = en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sig_valid      = sig_valid_q;

`ifdef ALU_SWEEP_SEQ_TRACE_EN
  logic        trace_valid_q;
  logic [3:0]  trace_opcode_q;
  logic [31:0] trace_result_q;
  logic [1:0]  trace_flags_q;

  // Registered copy of each capture, so the pulse lands one cycle after CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_q  <= 1'b0;
      trace_opcode_q <= '0;
      trace_result_q <= '0;
      trace_flags_q  <= '0;
    end else begin
      trace_valid_q <= shift;
      if (shift) begin
        trace_opcode_q <= opcode_q;
        trace_result_q <= alu.alu_result;
        trace_flags_q  <= {alu.alu_cout, alu.alu_bout};
      end
    end
  end

  assign trace_valid  = trace_valid_q;
  assign trace_opcode = trace_opcode_q;
  assign trace_result = trace_result_q;
  assign trace_flags  = trace_flags_q;
`endif

endmodule

// File: tb/tb_alu_sweep_seq.sv
// Self-checking bench: two sequencers (SETTLE=1 and 3) driving a behavioural ALU,
// checked against a sweep-level signature model.
module tb_alu_sweep_seq;
  import alu_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, abort, cin_in, bin_in, stub;
  logic [31:0] a_in, b_in;
  int          total = 0;
  int          bad = 0;

  logic        busy1, done1, sv1, busy3, done3, sv3;
  logic [31:0] sig1, sig3;
`ifdef ALU_SWEEP_SEQ_TRACE_EN
  logic        tv1, tv3;
  logic [3:0]  top1, top3;
  logic [31:0] tres1, tres3;
  logic [1:0]  tfl1, tfl3;
`endif

  always #5 clk = ~clk;

  alu_sweep_seq_if bus1();
  alu_sweep_seq_if bus3();

  alu_sweep_seq #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .bin_in(bin_in), .alu(bus1), .busy(busy1), .done(done1),
    .sig(sig1), .sig_valid(sv1)
`ifdef ALU_SWEEP_SEQ_TRACE_EN
    , .trace_valid(tv1), .trace_opcode(top1), .trace_result(tres1), .trace_flags(tfl1)
`endif
  );

  alu_sweep_seq #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .bin_in(bin_in), .alu(bus3), .busy(busy3), .done(done3),
    .sig(sig3), .sig_valid(sv3)
`ifdef ALU_SWEEP_SEQ_TRACE_EN
    , .trace_valid(tv3), .trace_opcode(top3), .trace_result(tres3), .trace_flags(tfl3)
`endif
  );

  // Behavioural ALU: returns {cout, bout, result}.
  function automatic logic [33:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                         logic ci, logic bi);
    logic [32:0] w;
    logic [31:0] r;
    logic        co, bo;
    co = 1'b0;
    bo = 1'b0;
    w  = '0;
    case (op)
      4'd0:    begin w = {1'b0, a} + {1'b0, b} + {32'd0, ci}; r = w[31:0]; co = w[32]; end
      4'd1:    begin w = {1'b0, a} - {1'b0, b} - {32'd0, bi}; r = w[31:0]; bo = w[32]; end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = a << b[4:0];
      4'd7:    r = a >> b[4:0];
      4'd8:    r = $signed(a) >>> b[4:0];
      4'd9:    r = a + 32'd1;
      4'd10:   r = a - 32'd1;
      4'd11:   r = {31'd0, $signed(a) < $signed(b)};
      4'd12:   r = {31'd0, a < b};
      4'd13:   r = ~a;
      4'd14:   r = b;
      default: r = {a[15:0], b[15:0]};
    endcase
    return {co, bo, r};
  endfunction

  assign {bus1.alu_cout, bus1.alu_bout, bus1.alu_result} = (stub || !bus1.alu_en) ? 34'd0 :
      alu_fn(bus1.alu_opcode, bus1.alu_a, bus1.alu_b, bus1.alu_cin, bus1.alu_bin);
  assign {bus3.alu_cout, bus3.alu_bout, bus3.alu_result} = (stub || !bus3.alu_en) ? 34'd0 :
      alu_fn(bus3.alu_opcode, bus3.alu_a, bus3.alu_b, bus3.alu_cin, bus3.alu_bin);

  // Expected signature of a whole sweep: seed, then one LFSR step plus XOR per opcode.
  function automatic logic [31:0] model_sig(logic [31:0] a, logic [31:0] b, logic ci,
                                            logic bi, logic zero);
    logic [31:0] s;
    logic [33:0] d;
    s = 32'hFFFF_FFFF;
    for (int op = 0; op < 16; op++) begin
      d = zero ? 34'd0 : alu_fn(4'(op), a, b, ci, bi);
      s = ((s << 1) | {31'd0, ^(s & 32'h8020_0003)}) ^ d[31:0] ^ {30'd0, d[33:32]};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sweep from edge 0 through cycle 70; optional abort, reset or held start.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic ci,
                     input logic bi, input int hold_until, input int abort_at,
                     input int rst_at);
    int   at1, at3, n1, n3, ntr;
    logic cut;
    at1 = 0; at3 = 0; n1 = 0; n3 = 0; ntr = 0;
    cut = (abort_at > 0) || (rst_at > 0);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = ci; bin_in = bi; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_c1", 64'(busy1), 64'd1);
        check("en_c1", 64'(bus1.alu_en), 64'd1);
        check("sv_cleared", 64'(sv1), 64'd0);
      end
      if (!cut && c <= 32) check("opcode1", 64'(bus1.alu_opcode), 64'((c - 1) / 2));
      if (!cut && c <= 64) check("opcode3", 64'(bus3.alu_opcode), 64'((c - 1) / 4));
      if (!cut && c == 40) begin
        check("a_latched", 64'(bus3.alu_a), 64'(a));
        check("b_latched", 64'(bus3.alu_b), 64'(b));
      end
      if (done1) begin n1++; at1 = c; end
      if (done3) begin n3++; at3 = c; end
      if (!cut && c == 33) check("busy_at_done", 64'(busy1), 64'd0);
`ifdef ALU_SWEEP_SEQ_TRACE_EN
      if (tv1 && !cut) begin
        check("trace_op", 64'(top1), 64'(ntr));
        check("trace_data", 64'({tfl1, tres1}),
              64'(stub ? 34'd0 : alu_fn(4'(ntr), a, b, ci, bi)));
        ntr++;
      end
`endif
      if (abort_at > 0 && c == abort_at + 1) begin
        check("abort_en", 64'(bus1.alu_en), 64'd0);
        check("abort_busy", 64'({busy1, busy3}), 64'd0);
        check("abort_sv", 64'({sv1, sv3}), 64'd0);
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        check("rst_ab", 64'({bus1.alu_a, bus1.alu_b}), 64'd0);
        check("rst_ctl", 64'({bus1.alu_cin, bus1.alu_bin, bus1.alu_opcode, bus1.alu_en}),
              64'd0);
        check("rst_status", 64'({busy1, done1, sv1, sig1}), 64'd0);
      end
      start = (c < hold_until);
      abort = (abort_at > 0 && c == abort_at);
      rst   = (rst_at > 0 && c == rst_at);
      if (c == 5) begin a_in = ~a; b_in = a ^ b ^ 32'h5A5A_0F0F; end
    end
    if (cut) begin
      check("no_done", 64'(n1 + n3), 64'd0);
      check("sv_low", 64'(sv1), 64'd0);
    end else begin
      check("ndone1", 64'(n1), 64'd1);
      check("done_cyc1", 64'(at1), 64'd33);
      check("ndone3", 64'(n3), 64'd1);
      check("done_cyc3", 64'(at3), 64'd65);
      check("sig1", 64'(sig1), 64'(model_sig(a, b, ci, bi, stub)));
      check("sig3", 64'(sig3), 64'(model_sig(a, b, ci, bi, stub)));
      check("sv_after", 64'({sv1, sv3}), 64'd3);
`ifdef ALU_SWEEP_SEQ_TRACE_EN
      check("trace_count", 64'(ntr), 64'd16);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stub = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; bin_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ab", 64'({bus1.alu_a, bus1.alu_b}), 64'd0);
    check("reset_ctl", 64'({bus1.alu_opcode, bus1.alu_en, bus1.alu_cin, bus1.alu_bin}), 64'd0);
    check("reset_status", 64'({busy1, done1, sv1, sig1}), 64'd0);
    rst = 1'b0;

    run(32'd10, 32'd5, 1'b0, 1'b0, 1, 0, 0);
    run(32'd10000, 32'd123, 1'b1, 1'b1, 1, 0, 0);
    stub = 1'b1;
    run($urandom, $urandom, 1'b1, 1'b0, 1, 0, 0);
    stub = 1'b0;
    run(32'd77, 32'd3, 1'b0, 1'b1, 1, 10, 0);
    run(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 1, 0, 0);
    run(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0, 20);
    run(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 30, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
